// File: rtl/matmul_pkg.sv
// Shared constants for the matmul operand scratchpad: operand select codes,
// default widths and the controller state encoding.
package matmul_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_BUS_WIDTH  = 16;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    localparam logic [4:0] OPERAND_A = 5'b00100;
    localparam logic [4:0] OPERAND_B = 5'b01000;
    localparam logic [4:0] OPERAND_C = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/matmul_operand_sp_if.sv
// Host register port of the matmul operand scratchpad.
interface matmul_operand_sp_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 16
);
    // Strobe semantics, no ready: every clock edge with host_we_i or host_re_i
    // high is one access; read data is presented on host_rdata_o the next cycle.
    logic                  host_we_i;
    logic                  host_re_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [BUS_WIDTH-1:0]  host_data_i;
    logic [BUS_WIDTH-1:0]  host_rdata_o;

    modport master (
        output host_we_i, host_re_i, host_addr_i, host_data_i,
        input  host_rdata_o
    );

    modport slave (
        input  host_we_i, host_re_i, host_addr_i, host_data_i,
        output host_rdata_o
    );
endinterface

// File: rtl/matmul_sp_addr_decode.sv
// Splits a scratchpad address into operand select, A/B row and C element
// index; legal is high only for the three defined select codes.
module matmul_sp_addr_decode
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int LOG        = 1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  sel_a,
    output logic                  sel_b,
    output logic                  sel_c,
    output logic                  legal,
    output logic [LOG-1:0]        row_idx,
    output logic [2*LOG-1:0]      c_idx
);
    // Address bits above the C index carry no meaning.
    logic unused_upper;
    assign unused_upper = ^addr[ADDR_WIDTH-1:5+2*LOG];

    assign sel_a   = (addr[4:0] == OPERAND_A);
    assign sel_b   = (addr[4:0] == OPERAND_B);
    assign sel_c   = (addr[4:0] == OPERAND_C);
    assign legal   = sel_a | sel_b | sel_c;
    assign row_idx = addr[5+LOG-1:5];
    assign c_idx   = addr[5+2*LOG-1:5];
endmodule

// File: rtl/matmul_operand_sp.sv
// Operand scratchpad for a matmul calc unit: host loads A/B/C, go streams them
// out, the calc unit writes C back and reports overflow flags on completion.
module matmul_operand_sp
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    matmul_operand_sp_if.slave    host,
    input  logic                  go_i,
    output logic                  start_o,
    output logic [BUS_WIDTH-1:0]  data_a_o,
    output logic [BUS_WIDTH-1:0]  data_b_o,
    output logic [BUS_WIDTH-1:0]  data_c_o,
    input  logic                  enable_w_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [BUS_WIDTH-1:0]  data_i,
    input  logic                  finish_mul_i,
    input  logic [BUS_WIDTH-1:0]  flags_i,
    output logic [BUS_WIDTH-1:0]  flags_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  addr_err_o,
    output state_t                state_o
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int LOG     = $clog2(MAX_DIM);
    localparam int CW      = 2 * LOG;
    localparam int NN      = MAX_DIM * MAX_DIM;
    localparam logic [CW-1:0] LAST_CNT = CW'(NN - 1);
    localparam logic [CW-1:0] DIM_CNT  = CW'(MAX_DIM);

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q;

    logic [BUS_WIDTH-1:0] mem_a [MAX_DIM];
    logic [BUS_WIDTH-1:0] mem_b [MAX_DIM];
    logic [BUS_WIDTH-1:0] mem_c [NN];
    logic [BUS_WIDTH-1:0] rdata_q, rd_val, flags_q;
    logic                 err_q;

    logic           h_sel_a, h_sel_b, h_sel_c, h_legal;
    logic [LOG-1:0] h_row;
    logic [CW-1:0]  h_cidx;
    logic           wb_sel_c, wb_unused_a, wb_unused_b, wb_unused_legal;
    logic [LOG-1:0] wb_unused_row;
    logic [CW-1:0]  wb_cidx;

    logic busy, wb_active, host_wr_ok, go_accept;

    matmul_sp_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .LOG(LOG)) u_host_dec (
        .addr    (host.host_addr_i),
        .sel_a   (h_sel_a),
        .sel_b   (h_sel_b),
        .sel_c   (h_sel_c),
        .legal   (h_legal),
        .row_idx (h_row),
        .c_idx   (h_cidx)
    );

    matmul_sp_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .LOG(LOG)) u_wb_dec (
        .addr    (address_i),
        .sel_a   (wb_unused_a),
        .sel_b   (wb_unused_b),
        .sel_c   (wb_sel_c),
        .legal   (wb_unused_legal),
        .row_idx (wb_unused_row),
        .c_idx   (wb_cidx)
    );

    assign busy       = (state_q == ST_FEED) || (state_q == ST_WAIT);
    assign wb_active  = enable_w_i && busy;
    assign go_accept  = (state_q == ST_IDLE) && go_i;
    // Write-back has priority; host stores only land while idle.
    assign host_wr_ok = host.host_we_i && h_legal && (state_q == ST_IDLE) && !wb_active;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ST_FEED && cnt_q != LAST_CNT) ? cnt_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go_i) state_d = ST_FEED;
            ST_FEED: if (cnt_q == LAST_CNT) state_d = ST_WAIT;
            ST_WAIT: if (finish_mul_i) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (h_sel_a)      rd_val = mem_a[h_row];
        else if (h_sel_b) rd_val = mem_b[h_row];
        else if (h_sel_c) rd_val = mem_c[h_cidx];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MAX_DIM; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            for (int i = 0; i < NN; i++) mem_c[i] <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
        end else begin
            err_q <= (host.host_we_i && (!h_legal || busy)) ||
                     (host.host_re_i && !h_legal) ||
                     (wb_active && !wb_sel_c);
            if (wb_active && wb_sel_c) mem_c[wb_cidx] <= data_i;
            if (host_wr_ok) begin
                if (h_sel_a)      mem_a[h_row]  <= host.host_data_i;
                else if (h_sel_b) mem_b[h_row]  <= host.host_data_i;
                else              mem_c[h_cidx] <= host.host_data_i;
            end
            if (host.host_re_i && h_legal) rdata_q <= rd_val;
            if (state_q == ST_WAIT && finish_mul_i) flags_q <= flags_i;
            else if (go_accept)                     flags_q <= '0;
        end
    end

    // A/B rows run out after MAX_DIM beats while C keeps streaming.
    always_comb begin
        data_a_o = '0;
        data_b_o = '0;
        data_c_o = '0;
        if (state_q == ST_FEED) begin
            data_c_o = mem_c[cnt_q];
            if (cnt_q < DIM_CNT) begin
                data_a_o = mem_a[cnt_q[LOG-1:0]];
                data_b_o = mem_b[cnt_q[LOG-1:0]];
            end
        end
    end

    assign start_o           = busy;
    assign busy_o            = busy;
    assign done_o            = (state_q == ST_DONE);
    assign addr_err_o        = err_q;
    assign flags_o           = flags_q;
    assign host.host_rdata_o = rdata_q;
    assign state_o           = state_q;
endmodule

// File: doc/matmul_operand_sp.md
MATMUL_OPERAND_SP -- requirements
Module: matmul_operand_sp

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 8, element width.
- BUS_WIDTH, 16, bus width.
- ADDR_WIDTH, 32, address width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, derived local constant, not overridable.
- LOG = $clog2(MAX_DIM).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- host_we_i  in  1  host write strobe.
- host_re_i  in  1  host read strobe.
- host_addr_i  in  ADDR_WIDTH  host address.
- host_data_i  in  BUS_WIDTH  host write data.
- host_rdata_o  out  BUS_WIDTH  host read data.
- go_i  in  1  launch one matmul.
- start_o  out  1  start to calc unit.
- data_a_o, data_b_o, data_c_o  out  BUS_WIDTH each  operand streams.
- enable_w_i  in  1  write-back strobe from calc unit.
- address_i  in  ADDR_WIDTH  write-back address.
- data_i  in  BUS_WIDTH  write-back data.
- finish_mul_i  in  1  calc unit finished writing C.
- flags_i  in  BUS_WIDTH  calc unit overflow flags.
- flags_o  out  BUS_WIDTH  latched flags.
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- addr_err_o  out  1  one-cycle illegal-access pulse.

Function
REQ-003 Address map: addr[4:0] is the operand select (A=5'b00100, B=5'b01000, C=5'b10000). A/B row index is addr[5+LOG-1:5]. C element index is addr[5+2*LOG-1:5]. Upper bits are ignored.
REQ-004 Storage is A[MAX_DIM], B[MAX_DIM] and C[MAX_DIM*MAX_DIM], each entry BUS_WIDTH wide.
REQ-005 Any other select value drops the access and pulses addr_err_o the next cycle.
REQ-006 Host write in IDLE stores the data the next cycle.
REQ-007 Host write while busy_o=1 is dropped and pulses addr_err_o.
REQ-008 Host read returns the selected entry on host_rdata_o one cycle after host_re_i. Reads are allowed in any state. When host_re_i=0, host_rdata_o holds its last value.
REQ-009 FSM states and transitions:
- IDLE to FEED on go_i.
- FEED to WAIT after MAX_DIM*MAX_DIM cycles.
- WAIT to DONE on finish_mul_i.
- DONE to IDLE after exactly one cycle.
REQ-010 go_i outside IDLE is ignored.
REQ-011 busy_o=1 in FEED and WAIT.
REQ-012 start_o=1 in FEED and WAIT only; it is registered and rises the cycle after go_i is sampled.
REQ-013 In FEED cycle t (t=0 is the first cycle with start_o=1):
- data_c_o = C[t].
- data_a_o = A[t] and data_b_o = B[t] for t<MAX_DIM; otherwise zero.
REQ-014 Outside FEED, all data_*_o are zero.
REQ-015 Write-back: when enable_w_i=1 in FEED or WAIT with select=C, C[index] <= data_i. Any other select drops the write and pulses addr_err_o. enable_w_i in IDLE or DONE is ignored.
REQ-016 finish_mul_i in WAIT latches flags_i into flags_o. flags_o holds until the next go_i is accepted, which clears it. finish_mul_i in any other state is ignored.
REQ-017 done_o=1 exactly in DONE; start_o is 0 in that same cycle.
REQ-018 Simultaneous events in one cycle:
- host write and write-back: write-back wins; host write is dropped.
- host read and write-back of the same entry: returns the old value.

Reset
REQ-019 On rst_i=1 at a clock edge:
- FSM goes to IDLE and the feed counter clears.
- All A, B and C entries clear to 0.
- All outputs go to 0.
REQ-020 Reset mid-operation aborts. start_o is 0 the cycle after, and no partial write-back persists.

Structure
REQ-021 Shared package (matmul_pkg) holds:
- OPERAND_A/B/C select codes;
- FSM state encoding;
- default DATA_WIDTH, BUS_WIDTH, ADDR_WIDTH.
REQ-022 One sub-module, matmul_sp_addr_decode: combinational select/index decode with a legal flag, instantiated twice (host port, write-back port).

Verification (MAX_DIM=2)
REQ-023 Cover these directed scenarios:
- Feed: load A={0x0201,0x0403}, B={0x0605,0x0807}, C={1,2,3,4}; pulse go -> next cycle start_o=1; A/B outputs 0x0201/0x0605 then 0x0403/0x0807 then 0; data_c_o=1,2,3,4 over four cycles; busy_o=1.
- Write-back: in WAIT, enable_w_i with address_i=0x50, data_i=0x002A -> host read of addr 0x50 returns 0x002A.
- Completion: finish_mul_i with flags_i=0x0005 in WAIT -> done_o pulses one cycle, start_o=0, flags_o=0x0005, busy_o=0.
- Busy protection: host write to 0x04 during FEED -> A[0] unchanged, addr_err_o pulses.
- Bad select: host write to address 0x03 -> addr_err_o pulses, no storage changes.
- Reset mid-FEED: rst_i at t=1 -> next cycle start_o=0, busy_o=0, all entries read 0.
